// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters.
// Winning operands are registered; DIV holds them for DIV_CYCLES; the response is tagged valid/ready.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned MAX_OPCODE = 10
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NUM_REQ-1:0]                               req_valid,
    output logic [NUM_REQ-1:0]                               req_ready,
    input  logic [4*NUM_REQ-1:0]                             req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0]                         req_a,
    input  logic [WIDTH*NUM_REQ-1:0]                         req_b,
    input  logic [5*NUM_REQ-1:0]                             req_shamt,
    output logic [3:0]                                       alu_opcode,
    output logic [WIDTH-1:0]                                 alu_input1,
    output logic [WIDTH-1:0]                                 alu_input2,
    output logic [4:0]                                       alu_shift,
    input  logic [WIDTH-1:0]                                 alu_result,
    input  logic                                             alu_carry,
    input  logic                                             alu_zero,
    input  logic                                             alu_sign,
    output logic                                             rsp_valid,
    input  logic                                             rsp_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic [WIDTH-1:0]                                 rsp_result,
    output logic [3:0]                                       rsp_flags,
    output logic                                             busy
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = ID_W + 1;
    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [3:0]  OP_DIV = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [4:0]         sh_q, sh_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               ill_q, ill_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]         rsp_flags_q, rsp_flags_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [SUM_W-1:0]   cand_sum;
    logic [3:0]         win_op;
    logic               win_ill;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + SUM_W'(k);
            if (cand_sum >= SUM_W'(NUM_REQ)) begin
                cand_sum = cand_sum - SUM_W'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[ID_W-1:0];
            end
        end
    end

    assign win_op  = req_opcode[4*32'(grant_idx) +: 4];
    assign win_ill = win_op > 4'(MAX_OPCODE);

    assign req_ready = (rst_n && (state_q == IDLE) && grant_found)
                     ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        sh_d         = sh_q;
        id_d         = id_q;
        ill_d        = ill_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    // Illegal opcodes present opcode 0 to the ALU; the result is discarded.
                    op_d    = win_ill ? 4'd0 : win_op;
                    ill_d   = win_ill;
                    a_d     = req_a[WIDTH*32'(grant_idx) +: WIDTH];
                    b_d     = req_b[WIDTH*32'(grant_idx) +: WIDTH];
                    sh_d    = req_shamt[5*32'(grant_idx) +: 5];
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if ((op_q == OP_DIV) && (cnt_q != CNT_W'(DIV_CYCLES - 1))) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d        = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = ill_q ? '0 : alu_result;
                    rsp_flags_d  = ill_q ? 4'b1010 : {1'b0, alu_carry, alu_zero, alu_sign};
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sh_q         <= '0;
            id_q         <= '0;
            ill_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sh_q         <= sh_d;
            id_q         <= id_d;
            ill_q        <= ill_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_opcode = op_q;
    assign alu_input1 = a_q;
    assign alu_input2 = b_q;
    assign alu_shift  = sh_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance (4-bit opcode, two WIDTH-bit operands, 5-bit shift amount, result plus carry/zero/sign flags) among NUM_REQ requesters.
- Arbitrates round-robin and registers the winning operands so the ALU inputs are stable.
- Holds DIV operands for DIV_CYCLES cycles to allow a multicycle divide path.
- Returns a tagged, registered response over a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- DIV_CYCLES, 4, cycles the ALU inputs are held for opcode DIV (4'd4); minimum 1
- MAX_OPCODE, 10, highest legal opcode; opcodes above it are illegal

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_opcode  in  4*NUM_REQ  packed opcodes; requester i at [4i+3:4i]
- req_a  in  WIDTH*NUM_REQ  packed operand 1
- req_b  in  WIDTH*NUM_REQ  packed operand 2
- req_shamt  in  5*NUM_REQ  packed shift amounts
- alu_opcode  out  4  to ALU opcode
- alu_input1  out  WIDTH  to ALU input1
- alu_input2  out  WIDTH  to ALU input2
- alu_shift  out  5  to ALU shiftValue
- alu_result  in  WIDTH  from ALU result
- alu_carry  in  1  from ALU carryFlag
- alu_zero  in  1  from ALU zeroFlag
- alu_sign  in  1  from ALU signFlag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  clog2(NUM_REQ) (min 1)  index of the requester being answered
- rsp_result  out  WIDTH  captured result
- rsp_flags  out  4  {err, carry, zero, sign}
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset (async assert, sync release):
  - all outputs 0; operand registers 0 (so alu_* outputs are 0)
  - priority pointer 0; div counter 0
- Reset mid-operation discards the in-flight transaction. No response is produced for it.
- IDLE:
  - Winner = first i with req_valid[i] set, searching from the pointer upward with wrap modulo NUM_REQ.
  - req_ready[winner] = 1 (combinational from req_valid and state); all other req_ready bits = 0.
  - If no req_valid bit is set, req_ready = 0 and the FSM stays in IDLE.
  - On accept (valid & ready at edge T):
    - latch opcode/a/b/shamt into the operand registers that drive alu_*
    - latch the winner id
    - pointer <= (winner+1) mod NUM_REQ
    - go to EXEC
- req_ready is 0 in EXEC and RESP. Requesters hold valid and payload stable until accepted.
- EXEC:
  - Legal non-DIV opcode: EXEC lasts 1 cycle. At its end, capture alu_result and the flags into rsp_* with err=0. Go to RESP.
  - DIV: EXEC lasts DIV_CYCLES cycles (counter 0..DIV_CYCLES-1). Capture on the last cycle, then go to RESP.
  - Illegal opcode (> MAX_OPCODE):
    - EXEC lasts 1 cycle
    - alu_opcode is forced to 4'd0 for that cycle
    - capture rsp_result=0, flags=4'b1010 (err=1, carry=0, zero=1, sign=0)
- RESP:
  - rsp_valid=1, with rsp_id/result/flags held stable.
  - When rsp_valid & rsp_ready, go to IDLE. rsp_valid is 0 in the next cycle.
  - No new request is accepted in RESP.
- Latency from the accept edge T to first rsp_valid:
  - T+2 for non-DIV and illegal opcodes
  - T+1+DIV_CYCLES for DIV
- Throughput: one op every 3 cycles minimum (non-DIV) when rsp_ready is held high.
- Operand registers hold their last value in IDLE. No ALU input toggles unless an accept occurs.
- DIV by zero is passed through unchanged; the ALU returns 0 and err=0.
- The fairness bound is guaranteed by the pointer update rule: a continuously valid requester waits at most NUM_REQ-1 grants.

Test Plan:
- Single ADD: req 2 sends opcode 6, a=5, b=7; rsp_ready=1 → rsp_valid at T+2, rsp_id=2, rsp_result=12, flags err=0 zero=0 sign=0.
- DIV hold, DIV_CYCLES=4: req 0 sends opcode 4, a=100, b=7 → alu_input1/input2 stay 100/7 for 4 EXEC cycles; rsp_valid at T+5; result=14.
- Round-robin: all 4 valid continuously with ADD → grant order 0,1,2,3,0; no requester is granted twice before all others are granted.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_valid, rsp_id, rsp_result and rsp_flags stable; req_ready=0 throughout; a second pending request is accepted only in the cycle after the response handshake.
- Illegal opcode 4'd13 from req 1 → rsp_result=0, rsp_flags=4'b1010, rsp_id=1, latency T+2.
- Reset mid-DIV: assert rst_n=0 in the second EXEC cycle → all outputs 0 immediately (async); after release, state is IDLE, pointer=0, no response is ever emitted for the aborted op.
